io_port_responder: RTL and testbench
====================================

Name: io_port_responder

Overview:
- Peripheral-side responder for the processor's I/O port at address 67.
- Consumes the sequence controller's PORT_EN (port write) and PORT_RD (port read) strobes.
- Buffers outgoing words in a small FIFO toward an external device over a valid/ready link.
- Holds one incoming word from the device until the core reads it onto the data bus.

Parameters:
- DATA_W, 32, data bus and port word width
- TX_DEPTH, 4, outgoing FIFO depth in words; must be a power of 2 and at least 2

Ports:
- CLK  input  1  system clock; all state changes on the rising edge
- RST_N  input  1  synchronous, active-low reset
- PORT_EN  input  1  port write strobe from the sequence controller; level, may be held several cycles
- PORT_RD  input  1  port read strobe from the sequence controller; level
- DATA_IN  input  DATA_W  core data bus, sampled on a PORT_EN write
- DATA_OUT  output  DATA_W  read data toward the core bus
- DATA_OE  output  1  DATA_OUT drives the bus while high
- TX_DATA  output  DATA_W  word at the FIFO head
- TX_VALID  output  1  FIFO not empty
- TX_READY  input  1  device accepts TX_DATA
- RX_DATA  input  DATA_W  incoming word from the device
- RX_VALID  input  1  RX_DATA is valid
- RX_READY  output  1  holding register is empty
- RX_AVAIL  output  1  holding register contains an unread word
- TX_FULL  output  1  FIFO count equals TX_DEPTH
- TX_OVF  output  1  sticky flag: a write was dropped

Behaviour:
- Reset (RST_N low at an edge):
  - FIFO pointers and count = 0; holding register = 0; all edge-detect registers = 0.
  - DATA_OUT = 0, DATA_OE = 0, TX_VALID = 0, RX_AVAIL = 0, TX_FULL = 0, TX_OVF = 0, RX_READY = 0 in the reset cycle.
  - Reset mid-transfer flushes everything; no partially accepted word survives.
- Strobe qualification: PORT_EN and PORT_RD are registered each cycle. Exactly one event is generated per rising level (strobe high now, low last cycle), regardless of how long the strobe is held.
- Port write event:
  - Pushes DATA_IN into the FIFO tail if count < TX_DEPTH, or if a TX pop occurs in the same cycle.
  - Otherwise the word is dropped and TX_OVF is set. TX_OVF stays set until reset.
- TX link:
  - TX_VALID = (count != 0); TX_DATA = mem[rd_ptr], both registered-state driven.
  - Pop on TX_VALID && TX_READY.
  - Pointers are log2(TX_DEPTH) bits and wrap modulo TX_DEPTH; count is log2(TX_DEPTH)+1 bits.
  - Push and pop in the same cycle leave count unchanged.
- RX link:
  - RX_READY = !RX_AVAIL (RX_READY is 0 during reset).
  - On RX_VALID && RX_READY: the holding register captures RX_DATA and RX_AVAIL is set at that edge.
- Port read event:
  - At the event edge, DATA_OUT is loaded with the holding register if RX_AVAIL = 1, else 0. DATA_OE goes to 1.
  - RX_AVAIL clears at the same edge. RX_READY rises in the following cycle, so a new word can be captured one cycle after the read.
  - DATA_OE stays 1 while PORT_RD stays high, then returns to 0 on the first edge where PORT_RD is sampled low. DATA_OUT holds its value.
  - Latency: PORT_RD high at edge N gives DATA_OE = 1 from N+1.
- Simultaneous events:
  - A write event and a read event in the same cycle are both serviced.
  - An RX capture cannot coincide with a consume, because RX_READY = 0 whenever RX_AVAIL = 1.

Optional Feature:
- Macro: IO_PORT_LOOPBACK_EN.
- Defined:
  - The FIFO head feeds the RX holding register internally. The internal valid is TX_VALID; the internal ready is !RX_AVAIL.
  - External TX_VALID is forced to 0, external RX_READY is forced to 0, and RX_DATA/RX_VALID are ignored.
- Undefined: the external links operate as described above; no loopback logic is present.

Decomposition:
- Shared package globe:
  - Add PORT_ADDR = 7'd67 and the port-strobe qualification enum (IDLE, ACTIVE).
  - Reuse the existing STATES typedef; no new phase types.
- One sub-module, port_tx_fifo: parameterised synchronous FIFO with push, pop, full, empty and count.
- The strobe edge detect, RX holding register and read logic stay in io_port_responder.

Test Plan:
- Reset then idle -> all outputs 0 except RX_READY = 1 after the first edge with RST_N high.
- PORT_EN held 3 cycles with DATA_IN = 32'hDEAD_BEEF, TX_READY = 0 -> count = 1 (single push); TX_VALID = 1; TX_DATA = 32'hDEAD_BEEF.
- 5 write events with values 1..5, TX_READY = 0, TX_DEPTH = 4 -> TX_FULL = 1 after the 4th; the 5th is dropped and TX_OVF = 1. Then TX_READY = 1 -> words 1, 2, 3, 4 are popped in order and TX_VALID falls.
- FIFO full plus a write event with TX_READY = 1 in the same cycle -> push accepted, count stays 4, TX_OVF stays 0.
- RX_VALID with RX_DATA = 32'h0000_1234 -> RX_AVAIL = 1, RX_READY = 0. Then PORT_RD high 2 cycles -> DATA_OE = 1 for 2 cycles with DATA_OUT = 32'h1234; RX_AVAIL clears; a new RX word is captured one cycle later.
- PORT_RD with RX_AVAIL = 0 -> DATA_OUT = 0, DATA_OE = 1. Reset asserted mid-FIFO with 3 words queued -> TX_VALID = 0 next cycle and count = 0.

Source files
------------

// File: rtl/globe.sv
// Shared definitions for the processor core and its peripherals.
// Holds the existing core phase type plus the I/O port constants and the
// port-strobe qualification states used by io_port_responder.
package globe;

  // Core sequencing phases (existing type, shared across the core).
  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEMORY,
    ST_WRITEBACK
  } STATES;

  // I/O port served by io_port_responder.
  localparam logic [6:0] PORT_ADDR = 7'd67;

  // Registered level of a port strobe, used to find its rising level.
  typedef enum logic {
    IDLE,
    ACTIVE
  } strobe_t;

  // True on the first cycle a strobe is seen high after being low.
  function automatic logic rising(input strobe_t prev, input logic now);
    return now && (prev == IDLE);
  endfunction

endpackage

// File: rtl/io_port_responder_tx_fifo.sv
// port_tx_fifo: synchronous FIFO for outgoing port words.
// DEPTH must be a power of 2 (pointers wrap naturally) and at least 2.
// Push while full is accepted only when a pop happens in the same cycle.
module port_tx_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        push_data,
  output logic [DATA_W-1:0]        head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);
  assign head_data = mem[rd_ptr];
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);

  // Pointer and occupancy bookkeeping; reset flushes any queued words.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Word storage.
  // NOTE: storage is deliberately not reset; the zeroed pointers and count
  // already make stale entries unreachable, and a reset-free array maps to RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/io_port_responder.sv
// io_port_responder: peripheral side of the processor I/O port (address 67).
// Qualifies PORT_EN/PORT_RD to one event per rising level, queues written
// words in port_tx_fifo toward the device, and holds one received word until
// the core reads it.
// Build option: define IO_PORT_LOOPBACK_EN to route the FIFO head straight
// into the receive holding register; the external TX/RX links then go idle.
module io_port_responder
  import globe::*;
#(
  parameter int DATA_W   = 32,
  parameter int TX_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              PORT_EN,
  input  logic              PORT_RD,
  input  logic [DATA_W-1:0] DATA_IN,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              DATA_OE,
  output logic [DATA_W-1:0] TX_DATA,
  output logic              TX_VALID,
  input  logic              TX_READY,
  input  logic [DATA_W-1:0] RX_DATA,
  input  logic              RX_VALID,
  output logic              RX_READY,
  output logic              RX_AVAIL,
  output logic              TX_FULL,
  output logic              TX_OVF
);

  localparam int CNT_W = $clog2(TX_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(TX_DEPTH);

  strobe_t           en_state, en_next;
  strobe_t           rd_state, rd_next;
  logic              wr_evt;
  logic              rd_evt;
  logic              wr_accept;
  logic              running;

  logic              fifo_pop;
  logic              tx_valid_int;
  logic              tx_full;
  logic              tx_empty;
  logic [CNT_W-1:0]  tx_count;
  logic [DATA_W-1:0] tx_head;

  logic              rx_valid_int;
  logic [DATA_W-1:0] rx_data_int;
  logic              rx_ready_int;
  logic              rx_cap;
  logic [DATA_W-1:0] rx_hold;
  logic              rx_avail;

  // Next strobe qualification state is simply the current strobe level.
  // NOTE: always_comb assigns every output on every path, so no latch is inferred.
  always_comb begin
    en_next = IDLE;
    rd_next = IDLE;
    if (PORT_EN) en_next = ACTIVE;
    if (PORT_RD) rd_next = ACTIVE;
  end

  // Strobe qualification registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      en_state <= IDLE;
      rd_state <= IDLE;
    end else begin
      en_state <= en_next;
      rd_state <= rd_next;
    end
  end

  assign wr_evt = rising(en_state, PORT_EN);
  assign rd_evt = rising(rd_state, PORT_RD);

  // A write lands if there is room now or the head leaves in the same cycle.
  assign wr_accept    = wr_evt && ((tx_count < DEPTH_CNT) || fifo_pop);
  assign tx_valid_int = !tx_empty;
  assign rx_ready_int = running && !rx_avail;
  assign rx_cap       = rx_valid_int && rx_ready_int;

`ifdef IO_PORT_LOOPBACK_EN
  logic unused_ext_link;
  assign unused_ext_link = ^{RX_DATA, RX_VALID, TX_READY};
  assign rx_valid_int    = tx_valid_int;
  assign rx_data_int     = tx_head;
  assign fifo_pop        = tx_valid_int && rx_ready_int;
  assign TX_VALID        = 1'b0;
  assign RX_READY        = 1'b0;
`else
  assign rx_valid_int = RX_VALID;
  assign rx_data_int  = RX_DATA;
  assign fifo_pop     = tx_valid_int && TX_READY;
  assign TX_VALID     = tx_valid_int;
  assign RX_READY     = rx_ready_int;
`endif

  port_tx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (TX_DEPTH)
  ) u_tx_fifo (
    .clk       (CLK),
    .rst_n     (RST_N),
    .push      (wr_evt),
    .pop       (fifo_pop),
    .push_data (DATA_IN),
    .head_data (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  assign TX_DATA  = tx_head;
  assign TX_FULL  = tx_full;
  assign RX_AVAIL = rx_avail;

  // Out-of-reset marker (keeps RX_READY low in the reset cycle) and sticky overflow.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      running <= 1'b0;
      TX_OVF  <= 1'b0;
    end else begin
      running <= 1'b1;
      if (wr_evt && !wr_accept) TX_OVF <= 1'b1;
    end
  end

  // Receive holding register: a read event consumes it, a handshake refills it.
  // Both cannot hit a full register at once because ready is low while it is full.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rx_hold  <= '0;
      rx_avail <= 1'b0;
    end else begin
      if (rd_evt) rx_avail <= 1'b0;
      if (rx_cap) begin
        rx_hold  <= rx_data_int;
        rx_avail <= 1'b1;
      end
    end
  end

  // Core read path: load on the read event, drive while PORT_RD stays high.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      DATA_OUT <= '0;
      DATA_OE  <= 1'b0;
    end else if (rd_evt) begin
      DATA_OUT <= rx_avail ? rx_hold : '0;
      DATA_OE  <= 1'b1;
    end else if (!PORT_RD) begin
      DATA_OE  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_io_port_responder.sv
// Self-checking bench for io_port_responder (default build, no loopback).
// A queue-based reference model tracks the expected outputs; a compare
// process checks them every falling edge, and directed scenarios add
// literal expectations before a randomized run.
module tb_io_port_responder;

  localparam int DATA_W   = 32;
  localparam int TX_DEPTH = 4;

  logic              clk;
  logic              rst_n;
  logic              port_en;
  logic              port_rd;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              data_oe;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              rx_avail;
  logic              tx_full;
  logic              tx_ovf;

  int checks = 0;
  int errors = 0;

  io_port_responder #(
    .DATA_W   (DATA_W),
    .TX_DEPTH (TX_DEPTH)
  ) dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .PORT_EN  (port_en),
    .PORT_RD  (port_rd),
    .DATA_IN  (data_in),
    .DATA_OUT (data_out),
    .DATA_OE  (data_oe),
    .TX_DATA  (tx_data),
    .TX_VALID (tx_valid),
    .TX_READY (tx_ready),
    .RX_DATA  (rx_data),
    .RX_VALID (rx_valid),
    .RX_READY (rx_ready),
    .RX_AVAIL (rx_avail),
    .TX_FULL  (tx_full),
    .TX_OVF   (tx_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  logic [DATA_W-1:0] mq[$];
  logic [DATA_W-1:0] m_hold, m_dout;
  bit m_avail, m_ovf, m_oe, m_run, m_pen, m_prd, m_known;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one rising edge using the inputs seen at that edge.
  task automatic model_step();
    bit wr, rd, pop, rdy, cap;
    m_known = 1'b1;
    if (!rst_n) begin
      mq.delete();
      m_hold = '0; m_dout = '0;
      m_avail = 0; m_ovf = 0; m_oe = 0; m_run = 0; m_pen = 0; m_prd = 0;
      return;
    end
    wr  = port_en && !m_pen;
    rd  = port_rd && !m_prd;
    pop = (mq.size() != 0) && tx_ready;
    rdy = m_run && !m_avail;
    cap = rx_valid && rdy;
    if (pop) void'(mq.pop_front());
    if (wr) begin
      if (mq.size() < TX_DEPTH) mq.push_back(data_in);
      else m_ovf = 1'b1;
    end
    if (rd) begin
      m_dout  = m_avail ? m_hold : '0;
      m_oe    = 1'b1;
      m_avail = 1'b0;
    end else if (!port_rd) begin
      m_oe = 1'b0;
    end
    if (cap) begin
      m_hold  = rx_data;
      m_avail = 1'b1;
    end
    m_run = 1'b1;
    m_pen = port_en;
    m_prd = port_rd;
  endtask

  always @(posedge clk) model_step();

  // Compare every output with the model away from the active edge.
  always @(negedge clk) begin
    if (m_known) begin
      check("tx_valid", {31'b0, tx_valid}, {31'b0, mq.size() != 0});
      if (mq.size() != 0) check("tx_data", tx_data, mq[0]);
      check("tx_full",  {31'b0, tx_full},  {31'b0, mq.size() == TX_DEPTH});
      check("tx_ovf",   {31'b0, tx_ovf},   {31'b0, m_ovf});
      check("rx_ready", {31'b0, rx_ready}, {31'b0, m_run && !m_avail});
      check("rx_avail", {31'b0, rx_avail}, {31'b0, m_avail});
      check("data_oe",  {31'b0, data_oe},  {31'b0, m_oe});
      check("data_out", data_out, m_dout);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [DATA_W-1:0] w);
    data_in = w;
    port_en = 1'b1;
    step();
    port_en = 1'b0;
    step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    rst_n = 1'b0; port_en = 0; port_rd = 0; data_in = '0;
    tx_ready = 0; rx_valid = 0; rx_data = '0;
    m_known = 0;

    // Reset then idle.
    step();
    check("rst_rx_ready", {31'b0, rx_ready}, 32'd0);
    check("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    check("rst_data_oe",  {31'b0, data_oe},  32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("idle_rx_ready", {31'b0, rx_ready}, 32'd1);
    check("idle_data_out", data_out, 32'd0);
    check("idle_tx_ovf",   {31'b0, tx_ovf}, 32'd0);

    // Held strobe gives a single push.
    data_in = 32'hDEAD_BEEF;
    port_en = 1'b1;
    repeat (3) step();
    port_en = 1'b0;
    step();
    check("held_model_count", mq.size(), 32'd1);
    check("held_tx_valid", {31'b0, tx_valid}, 32'd1);
    check("held_tx_data", tx_data, 32'hDEAD_BEEF);
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    check("held_drained", {31'b0, tx_valid}, 32'd0);

    // Fill, overflow, then drain in order.
    for (int v = 1; v <= 5; v++) begin
      write_word(DATA_W'(v));
      if (v == 4) check("fill_full", {31'b0, tx_full}, 32'd1);
    end
    check("ovf_set", {31'b0, tx_ovf}, 32'd1);
    check("ovf_model_count", mq.size(), 32'd4);
    tx_ready = 1'b1;
    for (int v = 1; v <= 4; v++) begin
      check("drain_order", tx_data, DATA_W'(v));
      step();
    end
    tx_ready = 1'b0;
    check("drain_empty", {31'b0, tx_valid}, 32'd0);
    check("ovf_sticky", {31'b0, tx_ovf}, 32'd1);

    // Full FIFO plus a write with a simultaneous pop.
    do_reset();
    for (int v = 10; v <= 13; v++) write_word(DATA_W'(v));
    check("full_again", {31'b0, tx_full}, 32'd1);
    data_in  = 32'd14;
    port_en  = 1'b1;
    tx_ready = 1'b1;
    step();
    port_en  = 1'b0;
    tx_ready = 1'b0;
    check("pushpop_full", {31'b0, tx_full}, 32'd1);
    check("pushpop_no_ovf", {31'b0, tx_ovf}, 32'd0);
    check("pushpop_head", tx_data, 32'd11);

    // Receive a word, read it for two cycles, capture the next one.
    rx_data  = 32'h0000_1234;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    check("rx_avail_set", {31'b0, rx_avail}, 32'd1);
    check("rx_ready_low", {31'b0, rx_ready}, 32'd0);
    port_rd = 1'b1;
    step();
    check("rd_oe_1", {31'b0, data_oe}, 32'd1);
    check("rd_data", data_out, 32'h0000_1234);
    check("rd_avail_clr", {31'b0, rx_avail}, 32'd0);
    rx_data  = 32'h0000_5678;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    check("rd_oe_2", {31'b0, data_oe}, 32'd1);
    check("rx_recapture", {31'b0, rx_avail}, 32'd1);
    port_rd = 1'b0;
    step();
    check("rd_oe_off", {31'b0, data_oe}, 32'd0);
    check("rd_data_hold", data_out, 32'h0000_1234);

    // Consume the second word, then read with nothing available.
    port_rd = 1'b1;
    step();
    port_rd = 1'b0;
    step();
    check("rd2_data", data_out, 32'h0000_5678);
    port_rd = 1'b1;
    step();
    check("rd_empty_data", data_out, 32'd0);
    check("rd_empty_oe", {31'b0, data_oe}, 32'd1);
    port_rd = 1'b0;
    step();

    // Reset with three words queued flushes the FIFO.
    do_reset();
    for (int v = 20; v <= 22; v++) write_word(DATA_W'(v));
    rst_n = 1'b0;
    step();
    check("flush_tx_valid", {31'b0, tx_valid}, 32'd0);
    rst_n = 1'b1;
    step();
    write_word(32'h0000_00AA);
    check("flush_head", tx_data, 32'h0000_00AA);

    // Randomized traffic checked against the model.
    for (int i = 0; i < 4000; i++) begin
      rst_n    = ($urandom_range(0, 199) != 0);
      port_en  = ($urandom_range(0, 9) < 4);
      port_rd  = ($urandom_range(0, 9) < 3);
      tx_ready = ($urandom_range(0, 9) < 4);
      rx_valid = ($urandom_range(0, 9) < 4);
      data_in  = $urandom;
      rx_data  = $urandom;
      step();
    end

    rst_n = 1'b1; port_en = 0; port_rd = 0; tx_ready = 0; rx_valid = 0;
    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
